// File: rtl/tiempo_pkg.sv
// Shared definitions for the pet clock time-of-day controller: FSM state encoding,
// field limits and the default system clock rate.
package tiempo_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } state_e;

  localparam int SEC_MAX          = 59;
  localparam int MIN_MAX          = 59;
  localparam int HOUR_MAX         = 23;
  localparam int FREQ_DEFAULT     = 50000000;
  localparam int FAST_DIV_DEFAULT = 16;

endpackage

// File: rtl/tiempo_prescaler.sv
// Free-running divide-by-DIV counter; tick is high during the cycle the count sits
// at DIV-1. clr restarts the period so the next tick lands exactly DIV cycles later.
module tiempo_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] cnt_q;

  assign tick = (cnt_q == PW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/tiempo_ctrl.sv
// Time-of-day controller with a RUN/SET_HOUR/SET_MIN edit FSM and event pulses.
// Define TIEMPO_FAST_EN to shorten the tick period to FAST_DIV cycles (sim/demo).
module tiempo_ctrl
  import tiempo_pkg::*;
#(
  parameter int FREQ     = FREQ_DEFAULT,
  parameter int FAST_DIV = FAST_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [1:0] set_field,
  output logic       blink,
  output logic       sec_tick,
  output logic       min_tick
);

`ifdef TIEMPO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int DIV = FAST ? FAST_DIV : FREQ;

  state_e     state_q;
  logic [5:0] sec_q;
  logic [5:0] min_q;
  logic [4:0] hour_q;
  logic       blink_q;
  logic       sec_tick_q;
  logic       min_tick_q;

  logic       tick;
  logic       pres_clr;
  logic       edit_inc;
  logic       edit_dec;
  logic [4:0] hour_d;
  logic [5:0] min_d;

  tiempo_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pres_clr),
    .tick (tick)
  );

  // A mode press swallows any edit in the same cycle, and inc+dec cancel out.
  always_comb begin
    edit_inc = btn_inc && !btn_dec && !btn_mode;
    edit_dec = btn_dec && !btn_inc && !btn_mode;
    pres_clr = (state_q == ST_SET_MIN) && btn_mode;

    hour_d = hour_q;
    if (edit_inc) begin
      hour_d = (hour_q == 5'(HOUR_MAX)) ? 5'd0 : hour_q + 5'd1;
    end else if (edit_dec) begin
      hour_d = (hour_q == 5'd0) ? 5'(HOUR_MAX) : hour_q - 5'd1;
    end

    min_d = min_q;
    if (edit_inc) begin
      min_d = (min_q == 6'(MIN_MAX)) ? 6'd0 : min_q + 6'd1;
    end else if (edit_dec) begin
      min_d = (min_q == 6'd0) ? 6'(MIN_MAX) : min_q - 6'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      blink_q    <= 1'b0;
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
    end else begin
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (tick) begin
            sec_tick_q <= 1'b1;
            if (sec_q == 6'(SEC_MAX)) begin
              sec_q      <= '0;
              min_tick_q <= 1'b1;
              if (min_q == 6'(MIN_MAX)) begin
                min_q  <= '0;
                hour_q <= (hour_q == 5'(HOUR_MAX)) ? 5'd0 : hour_q + 5'd1;
              end else begin
                min_q <= min_q + 6'd1;
              end
            end else begin
              sec_q <= sec_q + 6'd1;
            end
          end
          if (btn_mode) begin
            state_q <= ST_SET_HOUR;
            blink_q <= 1'b0;
          end
        end
        ST_SET_HOUR: begin
          if (tick) begin
            blink_q <= !blink_q;
          end
          if (btn_mode) begin
            state_q <= ST_SET_MIN;
          end
          hour_q <= hour_d;
        end
        ST_SET_MIN: begin
          // Leaving edit restarts the second so the first tick is a full period away.
          if (btn_mode) begin
            state_q <= ST_RUN;
            sec_q   <= '0;
            blink_q <= 1'b0;
          end else if (tick) begin
            blink_q <= !blink_q;
          end
          min_q <= min_d;
        end
        default: begin
          state_q <= ST_RUN;
          blink_q <= 1'b0;
        end
      endcase
    end
  end

  assign sec       = sec_q;
  assign min       = min_q;
  assign hour      = hour_q;
  assign set_field = state_q;
  assign blink     = blink_q;
  assign sec_tick  = sec_tick_q;
  assign min_tick  = min_tick_q;

endmodule

// File: tb/tb_tiempo_ctrl.sv
// Scoreboard bench for tiempo_ctrl at FREQ=4: the driver pushes the reference model's
// expected outputs per cycle and a monitor pops and compares after each clock edge.
module tb_tiempo_ctrl;

  localparam int FREQ = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btnMode = 1'b0;
  logic       btnInc = 1'b0;
  logic       btnDec = 1'b0;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [1:0] setField;
  logic       blink;
  logic       secTick;
  logic       minTick;

  typedef struct packed {
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [1:0] setField;
    logic       blink;
    logic       secTick;
    logic       minTick;
  } outVec_t;

  outVec_t expQ[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: time as seconds since midnight, prescaler as cycle phase.
  int todSec = 0;
  int modeSel = 0;
  int phase = 0;
  bit blinkM = 1'b0;

  tiempo_ctrl #(
    .FREQ     (FREQ),
    .FAST_DIV (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btnMode),
    .btn_inc   (btnInc),
    .btn_dec   (btnDec),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .set_field (setField),
    .blink     (blink),
    .sec_tick  (secTick),
    .min_tick  (minTick)
  );

  always #5 clk = ~clk;

  function automatic outVec_t modelOut(bit st, bit mt);
    outVec_t v;
    v.sec      = 6'(todSec % 60);
    v.min      = 6'((todSec / 60) % 60);
    v.hour     = 5'(todSec / 3600);
    v.setField = 2'(modeSel);
    v.blink    = blinkM;
    v.secTick  = st;
    v.minTick  = mt;
    return v;
  endfunction

  task automatic modelReset();
    todSec  = 0;
    modeSel = 0;
    phase   = 0;
    blinkM  = 1'b0;
  endtask

  task automatic modelStep(input bit r, input bit m, input bit inc, input bit dec, output outVec_t v);
    bit tickM;
    bit st;
    bit mt;
    bit doEdit;
    int field;
    st = 1'b0;
    mt = 1'b0;
    if (r) begin
      modelReset();
    end else begin
      tickM  = (phase == FREQ - 1);
      phase  = (phase + 1) % FREQ;
      doEdit = !m && (inc != dec);
      if (modeSel == 0) begin
        if (tickM) begin
          st     = 1'b1;
          mt     = (todSec % 60 == 59);
          todSec = (todSec + 1) % 86400;
        end
        if (m) begin
          modeSel = 1;
          blinkM  = 1'b0;
        end
      end else if (modeSel == 1) begin
        if (tickM) blinkM = !blinkM;
        if (m) modeSel = 2;
        if (doEdit) begin
          field  = (todSec / 3600 + (inc ? 1 : 23)) % 24;
          todSec = field * 3600 + todSec % 3600;
        end
      end else begin
        if (m) begin
          modeSel = 0;
          todSec  = todSec - todSec % 60;
          blinkM  = 1'b0;
          phase   = 0;
        end else begin
          if (tickM) blinkM = !blinkM;
          if (doEdit) begin
            field  = ((todSec / 60) % 60 + (inc ? 1 : 59)) % 60;
            todSec = (todSec / 3600) * 3600 + field * 60 + todSec % 60;
          end
        end
      end
    end
    v = modelOut(st, mt);
  endtask

  task automatic checkOutput(input outVec_t expV, input string tag);
    outVec_t act;
    act = '{sec, min, hour, setField, blink, secTick, minTick};
    vectors++;
    if (act !== expV) begin
      miscompares++;
      $display("[TB] FAIL %s t=%0t actual sec=%0d min=%0d hour=%0d field=%0d blink=%0b stick=%0b mtick=%0b required sec=%0d min=%0d hour=%0d field=%0d blink=%0b stick=%0b mtick=%0b",
               tag, $time, act.sec, act.min, act.hour, act.setField, act.blink, act.secTick, act.minTick,
               expV.sec, expV.min, expV.hour, expV.setField, expV.blink, expV.secTick, expV.minTick);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit m, input bit inc, input bit dec);
    outVec_t v;
    @(negedge clk);
    rst     = r;
    btnMode = m;
    btnInc  = inc;
    btnDec  = dec;
    modelStep(r, m, inc, dec, v);
    expQ.push_back(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resetCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Raise reset between edges and confirm outputs clear before the next clock edge.
  task automatic asyncResetCheck();
    @(negedge clk);
    btnMode = 1'b0;
    btnInc  = 1'b0;
    btnDec  = 1'b0;
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput(modelOut(1'b0, 1'b0), "asyncReset");
  endtask

  initial begin : monitor
    outVec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e, "scoreboard");
      end
    end
  end

  initial begin : watchdog
    #1000000;
    miscompares++;
    $display("[TB] FAIL watchdog t=%0t actual running required finished", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] timeout");
  end

  initial begin : driver
    int stimCount;
    stimCount = 0;
    resetCycles(3);

    // Free run through a minute rollover.
    idle(61 * FREQ + 2);

    // Set 23:59, return to RUN, run 59 s, then the midnight rollover.
    resetCycles(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(60 * FREQ + 3);

    // Hour wrap downward and frozen time with blinking.
    resetCycles(2);
    idle(5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    idle(8);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Minute wrap without hour carry, and simultaneous inc/dec.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(9);

    // Mode wins over inc, then return to RUN restarts the second.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2 * FREQ + 1);

    // Asynchronous reset in the middle of a minute edit at 37.
    resetCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 37; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    asyncResetCheck();
    resetCycles(2);

    // Randomized button traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 499) == 0), ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
      stimCount++;
    end
    idle(2);

    @(posedge clk);
    #3;
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL queueDrain actual %0d pending required 0", expQ.size());
    end
    if (vectors < stimCount) begin
      miscompares++;
      $display("[TB] FAIL vectorCount actual %0d required at least %0d", vectors, stimCount);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tiempo_ctrl.md
Name: tiempo_ctrl

Overview:
Time-of-day controller for the pet's clock: prescales the 50 MHz system clock to a 1 s tick and keeps hour/min/sec.
Adds a 3-state set-mode FSM so the user can adjust hour and minute with debounced button pulses.
Emits second/minute event pulses for downstream schedulers (hunger, sleep) and a blink flag for the display driver.

Parameters:
FREQ, 50000000, input clock cycles per second; must be >= 2
FAST_DIV, 16, tick period in cycles when TIEMPO_FAST_EN is defined; must be >= 2
PW, $clog2(FREQ), prescaler width (derived, not overridden)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  reset; asynchronous, active-high
btn_mode  in  1  one-cycle pulse, debounced upstream; cycles set mode
btn_inc  in  1  one-cycle pulse; increments the selected field
btn_dec  in  1  one-cycle pulse; decrements the selected field
sec  out  6  seconds 0-59
min  out  6  minutes 0-59
hour  out  5  hours 0-23
set_field  out  2  00=RUN, 01=SET_HOUR, 10=SET_MIN (11 unused)
blink  out  1  toggles on every tick while in SET_*; 0 in RUN
sec_tick  out  1  one-cycle pulse when sec advances in RUN
min_tick  out  1  one-cycle pulse when min advances by carry in RUN

Behaviour:
- Reset, asynchronous and immediate:
  - all outputs 0, prescaler 0, state RUN.
  - Reset mid-edit discards the edit and returns to 00:00:00 RUN.
- Prescaler:
  - counts 0..FREQ-1 and wraps.
  - tick is internal, high in the cycle the prescaler equals FREQ-1.
  - runs in all states.
- RUN, on tick:
  - sec+1.
  - At sec=59: sec->0, min+1, min_tick=1.
  - At min=59 as well: min->0, hour+1.
  - At hour=23 as well: hour->0 (23:59:59 -> 00:00:00).
  - sec_tick=1 on every tick.
  - Counter outputs and tick pulses are registered and change on the same clock edge.
- SET_HOUR / SET_MIN:
  - time does not advance.
  - sec_tick and min_tick are 0.
  - blink toggles on each tick.
- FSM on btn_mode: RUN->SET_HOUR->SET_MIN->RUN.
  - On entering SET_HOUR: blink<=0.
  - On SET_MIN->RUN: sec<=0, prescaler<=0, blink<=0, so the first sec_tick comes exactly FREQ cycles later.
- Field edit, SET_HOUR:
  - inc: 23->0 wrap, otherwise +1.
  - dec: 0->23 wrap, otherwise -1.
- Field edit, SET_MIN:
  - inc: 59->0; dec: 0->59.
  - No carry or borrow into hour.
- In RUN, btn_inc and btn_dec are ignored.
- Simultaneous events:
  - btn_inc and btn_dec together: both ignored.
  - btn_mode with inc or dec: mode wins; the edit is dropped and applies to neither field.
  - tick coinciding with SET_MIN->RUN: the return to RUN takes priority and the prescaler is cleared; no sec advance that cycle.
- set_field is a direct registered encoding of the state.
- Latency: button pulse to field/state change is 1 cycle.

Optional Feature:
TIEMPO_FAST_EN
- Defined: tick period is FAST_DIV cycles and prescaler compare is FAST_DIV-1. Used for simulation and board demo.
- Undefined: period is FREQ cycles.
- Ports and all other behaviour are identical either way.

Decomposition:
- Shared package tiempo_pkg holds:
  - state encoding constants ST_RUN=2'b00, ST_SET_HOUR=2'b01, ST_SET_MIN=2'b10.
  - limits SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - default FREQ.
- One natural sub-module: tiempo_prescaler.
  - Params DIV; inputs clk, rst, clr; output tick.
  - Instantiated once.
  - clr is driven on SET_MIN->RUN.
- FSM and counters stay in tiempo_ctrl.

Test Plan:
All scenarios use FREQ=4, TIEMPO_FAST_EN undefined.
1. Reset held 3 cycles, then released: all outputs 0. First sec_tick occurs on cycle 4 after release with sec=1. After 60 ticks: sec=0, min=1, one min_tick.
2. Force 23:59:59 via set mode plus 59 ticks, then one tick -> 00:00:00. min_tick=1 and sec_tick=1 in the same cycle.
3. btn_mode, then btn_dec with hour=0 -> set_field=01, hour=23, time frozen across 8 cycles, blink toggles twice.
4. In SET_MIN at min=59, btn_inc -> min=0, hour unchanged. btn_inc and btn_dec in the same cycle -> no change.
5. btn_mode and btn_inc in the same cycle in SET_HOUR -> set_field=10, hour unchanged. Next btn_mode -> RUN, sec=0, next sec_tick exactly 4 cycles later.
6. Assert rst asynchronously mid-cycle while in SET_MIN with min=37 -> outputs 0 and set_field=00 before the next clk edge.
